// File: rtl/leddc_scan_scheduler.sv
// leddc_scan_scheduler
//   Scanline scheduler for the LEDDC, running entirely on GCK. Displays one
//   bank of a ping-pong frame buffer (2 banks x N_LINE lines x N_CH words),
//   prefetching each line's grayscale words into the PWM shadow registers and
//   issuing pwm_load on the Vsync rising edge. Bank swaps happen only at the
//   frame wrap, so a displayed frame is never torn.
//
//   Build option: define LEDDC_SCAN_REV_EN to scan lines N_LINE-1 down to 0
//   (wrap 0 -> N_LINE-1). Undefined: ascending 0 -> N_LINE-1.
//
// Ports
//   GCK, rst            clock, asynchronous active-high reset
//   Vsync               scanline PWM window (GCK-synchronous)
//   frame_done          1-cycle pulse: writer finished bank wr_bank
//   sram_rd/sram_addr   read strobe, address {rd_bank, line, idx}
//   sram_q              read data, valid one cycle after sram_rd
//   gray_wr/idx/data    shadow-register write to the PWM engine
//   pwm_load            1-cycle pulse: shadow -> active, restart PWM
//   scan_line           line on display (updated with pwm_load)
//   wr_bank/rd_bank     bank being written / displayed
//   disp_en             high once the first frame has been accepted
//   frame_skip          1-cycle pulse: pending frame overwritten
//   underrun            sticky: Vsync rose before the prefetch finished
module leddc_scan_scheduler #(
  parameter int N_LINE = 32,
  parameter int N_CH   = 16,
  parameter int DW     = 16,
  parameter int AW     = 10
) (
  input  logic          GCK,
  input  logic          rst,
  input  logic          Vsync,
  input  logic          frame_done,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_q,
  output logic          gray_wr,
  output logic [3:0]    gray_idx,
  output logic [DW-1:0] gray_data,
  output logic          pwm_load,
  output logic [4:0]    scan_line,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          disp_en,
  output logic          frame_skip,
  output logic          underrun
);

  localparam int LW = $clog2(N_LINE);
  localparam int CW = $clog2(N_CH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;

`ifdef LEDDC_SCAN_REV_EN
  localparam logic [LW-1:0] LINE_FIRST = '1;
  localparam logic [LW-1:0] LINE_LAST  = '0;
`else
  localparam logic [LW-1:0] LINE_FIRST = '0;
  localparam logic [LW-1:0] LINE_LAST  = '1;
`endif

  logic [2:0]    state_q,      state_d;
  logic [LW-1:0] line_q,       line_d;
  logic [CW-1:0] k_q,          k_d;
  logic          vs_q,         vs_d;
  logic          vs_pend_q,    vs_pend_d;
  logic          swap_pend_q,  swap_pend_d;
  logic          rd_bank_q,    rd_bank_d;
  logic          wr_bank_q,    wr_bank_d;
  logic          disp_en_q,    disp_en_d;
  logic          pwm_load_q,   pwm_load_d;
  logic [LW-1:0] scan_line_q,  scan_line_d;
  logic          frame_skip_q, frame_skip_d;
  logic          underrun_q,   underrun_d;
  logic          gray_wr_q,    gray_wr_d;
  logic [3:0]    gray_idx_q,   gray_idx_d;
  logic [DW-1:0] gray_data_q,  gray_data_d;

  logic rise, fall, wrap;

  assign rise = Vsync & ~vs_q;
  assign fall = ~Vsync & vs_q;
  assign wrap = (state_q == S_SCAN) && fall && (line_q == LINE_LAST);

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    k_d          = k_q;
    vs_d         = Vsync;
    vs_pend_d    = vs_pend_q;
    swap_pend_d  = swap_pend_q;
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q;
    disp_en_d    = disp_en_q;
    pwm_load_d   = 1'b0;
    scan_line_d  = scan_line_q;
    frame_skip_d = 1'b0;
    underrun_d   = underrun_q;
    gray_wr_d    = 1'b0;
    gray_idx_d   = gray_idx_q;
    // Read data arrives one cycle after the strobe, so it is forwarded
    // combinationally and captured to hold once the burst ends.
    gray_data_d  = gray_wr_q ? sram_q : gray_data_q;

    // A frame_done coinciding with the wrap is consumed by the swap below.
    if ((state_q != S_IDLE) && frame_done && !wrap) begin
      swap_pend_d  = 1'b1;
      frame_skip_d = swap_pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          disp_en_d = 1'b1;
          line_d    = LINE_FIRST;
          k_d       = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        gray_wr_d  = 1'b1;
        gray_idx_d = 4'(k_q);
        k_d        = k_q + 1'b1;
        if (k_q == '1) state_d = S_DRAIN;
        if (rise) begin
          vs_pend_d  = 1'b1;
          underrun_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // An early rise loads on the first READY cycle; vs_pend stays set so
        // READY knows the load already happened and moves straight to SCAN.
        if (rise || vs_pend_q) begin
          pwm_load_d  = 1'b1;
          scan_line_d = line_q;
          vs_pend_d   = 1'b1;
        end
        if (rise) underrun_d = 1'b1;
        state_d = S_READY;
      end
      S_READY: begin
        if (vs_pend_q) begin
          vs_pend_d = 1'b0;
          state_d   = S_SCAN;
        end else if (rise) begin
          pwm_load_d  = 1'b1;
          scan_line_d = line_q;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (fall) begin
`ifdef LEDDC_SCAN_REV_EN
          line_d = line_q - 1'b1;
`else
          line_d = line_q + 1'b1;
`endif
          k_d     = '0;
          state_d = S_FETCH;
          if (wrap && (swap_pend_q || frame_done)) begin
            rd_bank_d   = wr_bank_q;
            wr_bank_d   = rd_bank_q;
            swap_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge GCK or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      k_q          <= '0;
      vs_q         <= 1'b0;
      vs_pend_q    <= 1'b0;
      swap_pend_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      disp_en_q    <= 1'b0;
      pwm_load_q   <= 1'b0;
      scan_line_q  <= '0;
      frame_skip_q <= 1'b0;
      underrun_q   <= 1'b0;
      gray_wr_q    <= 1'b0;
      gray_idx_q   <= '0;
      gray_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      k_q          <= k_d;
      vs_q         <= vs_d;
      vs_pend_q    <= vs_pend_d;
      swap_pend_q  <= swap_pend_d;
      rd_bank_q    <= rd_bank_d;
      wr_bank_q    <= wr_bank_d;
      disp_en_q    <= disp_en_d;
      pwm_load_q   <= pwm_load_d;
      scan_line_q  <= scan_line_d;
      frame_skip_q <= frame_skip_d;
      underrun_q   <= underrun_d;
      gray_wr_q    <= gray_wr_d;
      gray_idx_q   <= gray_idx_d;
      gray_data_q  <= gray_data_d;
    end
  end

  assign sram_rd    = (state_q == S_FETCH);
  assign sram_addr  = sram_rd ? {rd_bank_q, line_q, k_q} : '0;
  assign gray_wr    = gray_wr_q;
  assign gray_idx   = gray_idx_q;
  assign gray_data  = gray_data_d;
  assign pwm_load   = pwm_load_q;
  assign scan_line  = 5'(scan_line_q);
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign disp_en    = disp_en_q;
  assign frame_skip = frame_skip_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_leddc_scan_scheduler.sv
// Directed bench for leddc_scan_scheduler: idle behaviour, prefetch timing and
// data, pwm_load timing, bank swap/repeat/skip rules, underrun, reset abort.
module tb_leddc_scan_scheduler;

  logic        GCK = 1'b0;
  logic        rst = 1'b1;
  logic        Vsync = 1'b0;
  logic        frame_done = 1'b0;
  logic        sram_rd;
  logic [9:0]  sram_addr;
  logic [15:0] sram_q;
  logic        gray_wr;
  logic [3:0]  gray_idx;
  logic [15:0] gray_data;
  logic        pwm_load;
  logic [4:0]  scan_line;
  logic        wr_bank, rd_bank, disp_en, frame_skip, underrun;

  leddc_scan_scheduler #(.N_LINE(32), .N_CH(16), .DW(16), .AW(10)) dut (
    .GCK(GCK), .rst(rst), .Vsync(Vsync), .frame_done(frame_done),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_q(sram_q),
    .gray_wr(gray_wr), .gray_idx(gray_idx), .gray_data(gray_data),
    .pwm_load(pwm_load), .scan_line(scan_line), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .disp_en(disp_en), .frame_skip(frame_skip),
    .underrun(underrun)
  );

  always #5 GCK = ~GCK;

`ifdef LEDDC_SCAN_REV_EN
  localparam logic [4:0] L_FIRST = 5'd31;
  localparam logic [4:0] L_LAST  = 5'd0;
`else
  localparam logic [4:0] L_FIRST = 5'd0;
  localparam logic [4:0] L_LAST  = 5'd31;
`endif

  function automatic logic [4:0] nxt(input logic [4:0] l);
`ifdef LEDDC_SCAN_REV_EN
    return l - 5'd1;
`else
    return l + 5'd1;
`endif
  endfunction

  function automatic logic [15:0] mem_val(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hC35A;
  endfunction

  // SRAM model: registered read, data one cycle after the strobe
  always @(posedge GCK) if (sram_rd) sram_q <= mem_val(sram_addr);

  int checks = 0;
  int failures = 0;

  logic       exp_rd = 1'b0;
  logic       exp_wr = 1'b0;
  logic       swap_pend_m = 1'b0;
  logic [4:0] cur_line = 5'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge GCK);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {sram_rd, sram_addr, gray_wr, gray_idx, gray_data, pwm_load,
                scan_line, wr_bank, rd_bank, disp_en, frame_skip, underrun}, 64'd0);
  endtask

  // Called in the first FETCH cycle; returns in the first READY cycle.
  task automatic fetch_phase(input logic [4:0] ln, input bit chk);
    logic [9:0] base;
    base = {exp_rd, ln, 4'h0};
    for (int unsigned i = 0; i < 17; i++) begin
      if (chk) begin
        if (i < 16) begin
          check("sram_rd", sram_rd, 1);
          check("sram_addr", sram_addr, base | 10'(i));
        end
        if (i >= 1) begin
          check("gray_wr", gray_wr, 1);
          check("gray_idx", gray_idx, 4'(i - 1));
          check("gray_data", gray_data, mem_val(base | 10'(i - 1)));
        end
      end
      tick;
    end
    if (chk) begin
      check("sram_rd_off", sram_rd, 0);
      check("gray_wr_off", gray_wr, 0);
      check("gray_hold", gray_data, mem_val(base | 10'd15));
    end
  endtask

  // Called in READY; returns in the first FETCH cycle of the next line.
  task automatic scan_cycle(input logic [4:0] ln, input bit chk, input bit fd_at_fall);
    Vsync = 1'b1;
    tick;
    if (chk) begin
      check("pwm_load", pwm_load, 1);
      check("scan_line", scan_line, ln);
    end
    tick;
    if (chk) check("pwm_load_pulse", pwm_load, 0);
    tick;
    Vsync = 1'b0;
    if (fd_at_fall) frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    if (ln == L_LAST && (swap_pend_m || fd_at_fall)) begin
      exp_rd = ~exp_rd;
      exp_wr = ~exp_wr;
      swap_pend_m = 1'b0;
    end
    if (fd_at_fall) check("frame_skip_wrap", frame_skip, 0);
  endtask

  task automatic pulse_fd;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    check("frame_skip", frame_skip, swap_pend_m);
    swap_pend_m = 1'b1;
    tick;
    check("frame_skip_pulse", frame_skip, 0);
  endtask

  // Runs one full frame starting in READY of the first line.
  task automatic run_frame(input int fd_a, input int fd_b, input bit fd_wrap);
    logic [4:0] ln;
    bit chk;
    for (int j = 0; j < 32; j++) begin
      ln = cur_line;
      chk = (j == 0) || (j == 31);
      if (j == fd_a || j == fd_b) pulse_fd;
      scan_cycle(ln, chk, fd_wrap && (ln == L_LAST));
      cur_line = nxt(ln);
      fetch_phase(cur_line, chk);
      check("rd_bank", rd_bank, exp_rd);
      check("wr_bank", wr_bank, exp_wr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle: Vsync toggles without frame_done do nothing
    tick;
    tick;
    check_quiet("reset");
    rst = 1'b0;
    for (int unsigned t = 0; t < 3; t++) begin
      Vsync = 1'b1;
      tick;
      tick;
      check_quiet("idle_vs_hi");
      Vsync = 1'b0;
      tick;
      tick;
      check_quiet("idle_vs_lo");
    end

    // First frame_done starts the first prefetch
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    exp_rd = 1'b0;
    exp_wr = 1'b1;
    check("wr_bank_first", wr_bank, 1);
    check("rd_bank_first", rd_bank, 0);
    check("disp_en", disp_en, 1);
    cur_line = L_FIRST;
    fetch_phase(cur_line, 1);

    // Frame A: new frame arrives mid-frame, swap at wrap
    run_frame(10, -1, 1'b0);
    // Frame B: two frames in one display frame -> one skip, one swap
    run_frame(3, 5, 1'b0);
    // Frame C: nothing pending -> same bank repeats
    run_frame(-1, -1, 1'b0);
    // Frame D: frame_done on the wrap cycle swaps immediately
    run_frame(-1, -1, 1'b1);

    // Underrun: Vsync rises 5 cycles after the fall that started a fetch
    Vsync = 1'b1;
    tick;
    check("pwm_load_pre_ur", pwm_load, 1);
    tick;
    Vsync = 1'b0;
    tick;
    cur_line = nxt(cur_line);
    check("ur_fetch_addr", sram_addr, {exp_rd, cur_line, 4'h0});
    for (int unsigned t = 0; t < 4; t++) tick;
    Vsync = 1'b1;
    tick;
    check("underrun_set", underrun, 1);
    check("pwm_load_not_early", pwm_load, 0);
    for (int unsigned t = 0; t < 11; t++) tick;
    check("pwm_load_in_drain", pwm_load, 0);
    tick;
    check("pwm_load_after_drain", pwm_load, 1);
    check("scan_line_ur", scan_line, cur_line);
    tick;
    check("pwm_load_ur_pulse", pwm_load, 0);
    check("underrun_sticky", underrun, 1);
    Vsync = 1'b0;
    tick;
    cur_line = nxt(cur_line);
    check("post_ur_fetch", sram_addr, {exp_rd, cur_line, 4'h0});

    // Reset mid-fetch aborts at once
    tick;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    tick;
    rst = 1'b0;
    for (int unsigned t = 0; t < 3; t++) begin
      tick;
      check_quiet("rst_idle");
    end
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    exp_rd = 1'b0;
    exp_wr = 1'b1;
    swap_pend_m = 1'b0;
    check("wr_bank_restart", wr_bank, 1);
    cur_line = L_FIRST;
    fetch_phase(cur_line, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
